// File: rtl/collision_matrix_pkg.sv
// collision_pkg: shared constants and pair-indexing helpers for the collision matrix.
package collision_pkg;
  localparam int MAX_OBJ = 8;
  localparam int MAX_PAIRS = MAX_OBJ * (MAX_OBJ - 1) / 2;
  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction
  // Pairs with first index i are preceded by (n-1)+(n-2)+...+(n-i) lower-indexed pairs.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction
  function automatic logic [4:0] popcount(input logic [MAX_PAIRS-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < MAX_PAIRS; k++) c = c + 5'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/collision_matrix_pair_flag.sv
// collision_pair_flag: per-pair once-per-frame hit pulse and armed flag.
module collision_pair_flag (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic overlap,
  output logic hit_pulse,
  output logic flag_q
);
  logic fire;
  // A frame start re-arms the pair in the same cycle, so an overlap there still fires.
  assign fire = overlap & (startOfFrame | ~flag_q);
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_pulse <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      hit_pulse <= fire;
      flag_q    <= (startOfFrame ? 1'b0 : flag_q) | fire;
    end
  end
endmodule

// File: rtl/collision_matrix.sv
// collision_matrix: pairwise sprite overlap detector with per-frame hit pulses, summary and saturating count.
module collision_matrix
  import collision_pkg::*;
#(
  parameter  int NUM_OBJ   = 4,
  parameter  int CNT_W     = 8,
  localparam int NUM_PAIRS = num_pairs(NUM_OBJ)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_OBJ-1:0]   draw_req,
  input  logic [NUM_PAIRS-1:0] pair_en,
  input  logic                 count_clr,
  output logic                 collision,
  output logic [NUM_PAIRS-1:0] hit_pulse,
  output logic                 any_hit,
  output logic [NUM_PAIRS-1:0] frame_hits,
  output logic [CNT_W-1:0]     hit_count
);
  localparam logic [CNT_W+3:0] CNT_MAX = (CNT_W + 4)'({CNT_W{1'b1}});
  logic [NUM_PAIRS-1:0] overlap;
  logic [NUM_PAIRS-1:0] flag;
  logic [CNT_W+3:0]     sum;
  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_j
      assign overlap[pair_idx(i, j, NUM_OBJ)] = draw_req[i] & draw_req[j] & pair_en[pair_idx(i, j, NUM_OBJ)];
    end
  end
  assign collision = |overlap;
  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
    collision_pair_flag u_flag (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .overlap      (overlap[k]),
      .hit_pulse    (hit_pulse[k]),
      .flag_q       (flag[k])
    );
  end
  // Widened so adding a full pulse vector to a near-max count cannot wrap before saturation.
  assign sum = (CNT_W + 4)'(hit_count) + (CNT_W + 4)'(popcount(MAX_PAIRS'(hit_pulse)));
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      any_hit    <= 1'b0;
      frame_hits <= '0;
      hit_count  <= '0;
    end else begin
      any_hit    <= |(overlap & ({NUM_PAIRS{startOfFrame}} | ~flag));
      frame_hits <= startOfFrame ? flag : frame_hits;
      hit_count  <= count_clr ? '0 : (sum > CNT_MAX ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0]);
    end
  end
endmodule

// File: doc/collision_matrix.md
# collision_matrix

Parametrised per-frame collision detector for the VGA game pipeline. Takes the drawing-request lines of NUM_OBJ sprite layers and finds every overlapping pair each pixel clock. It issues at most one registered hit pulse per enabled pair per frame, latches a per-pair hit summary for the completed frame, and keeps a saturating event counter. It sits between the object drawers and the game-logic FSM, and replaces the fixed three-object controller.

## Interface
- NUM_OBJ, 4: number of drawing-request inputs; legal range 2..8.
- CNT_W, 8: width of hit_count.
- NUM_PAIRS (derived, not overridable): NUM_OBJ*(NUM_OBJ-1)/2.
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse at frame start.
- draw_req  in  NUM_OBJ  drawing request per object, bit k = object k.
- pair_en  in  NUM_PAIRS  per-pair enable; a disabled pair never collides.
- count_clr  in  1  synchronous clear of hit_count.
- collision  out  1  combinational OR of all enabled pair overlaps.
- hit_pulse  out  NUM_PAIRS  registered per-pair single pulse, at most one per pair per frame.
- any_hit  out  1  registered OR of hit_pulse.
- frame_hits  out  NUM_PAIRS  per-pair hit summary of the last completed frame.
- hit_count  out  CNT_W  total pair events since reset or clear; saturating.

## Operation
- Pair index p(i,j) for i<j enumerates i ascending, then j ascending. For NUM_OBJ=4: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- overlap[p] = draw_req[i] & draw_req[j] & pair_en[p]. This is combinational, and collision = |overlap.
- Each pair has a flag register, one per pair. The flag is set when that pair's pulse fires and is cleared by startOfFrame.
- Pulse rule per pair: hit_pulse[p] <= overlap[p] & (startOfFrame | ~flag[p]).
  - A startOfFrame cycle counts as a clear flag, so an overlap in that same cycle fires and re-arms the flag for the new frame.
- Flag rule: flag[p] <= (startOfFrame ? 0 : flag[p]) | (overlap[p] & (startOfFrame | ~flag[p])).
- frame_hits: on a startOfFrame cycle, frame_hits <= flag, using the pre-update value (the closing frame's hits). frame_hits holds otherwise.
- hit_count:
  - When count_clr is high, hit_count <= 0; count_clr has priority over increment.
  - Otherwise hit_count <= min(hit_count + popcount(hit_pulse), 2^CNT_W-1).
  - Evaluate the sum CNT_W+4 bits wide before the saturation compare.
- Toggling pair_en mid-frame affects only future overlaps. It does not clear the flag or frame_hits.

## Timing
- Reset values: hit_pulse=0, any_hit=0, flag=0, frame_hits=0, hit_count=0. collision follows its inputs even while resetN is low.
- Latency:
  - overlap to hit_pulse/any_hit is 1 cycle.
  - hit_pulse to hit_count is 1 further cycle.
  - startOfFrame to frame_hits is 1 cycle.
- hit_pulse is exactly one cycle wide and never fires twice for the same p between consecutive startOfFrame pulses. Continuous overlap across a frame boundary gives one pulse per frame.
- Different pairs are independent; several bits of hit_pulse may assert in the same cycle.
- Asserting resetN mid-frame clears everything asynchronously. The first overlap after release fires even without startOfFrame.

## Structure
- Package collision_pkg holds:
  - function num_pairs(n);
  - function pair_idx(i,j,n) returning p(i,j);
  - function popcount(vector) for up to 28 bits;
  - localparam MAX_OBJ=8.
- One sub-module, collision_pair_flag, holds the flag and pulse for one pair. Its inputs are clk, resetN, startOfFrame and overlap; its outputs are hit_pulse and flag_q. It is instantiated NUM_PAIRS times in a generate loop.
- The top level holds the overlap generate, frame_hits, any_hit and the saturating counter.

## Test plan
All scenarios use NUM_OBJ=4 and CNT_W=8 unless noted.
- Single pair: pair_en=6'h3F, draw_req=4'b0011 held for 100 cycles mid-frame. Expect hit_pulse=6'b000001 for exactly one cycle, 1 cycle after the first overlap; collision high throughout; hit_count=1.
- Frame boundary: hold draw_req=4'b0011 across a startOfFrame. Expect a second pulse in the cycle after startOfFrame, and frame_hits=6'b000001 one cycle after startOfFrame.
- Multi-pair: draw_req=4'b1111 for one cycle. Expect hit_pulse=6'h3F, any_hit=1 and hit_count += 6.
- Mask: pair_en=6'b111110 with draw_req=4'b0011. Expect collision=0, no pulse and hit_count unchanged. Then draw_req=4'b0101: expect hit_pulse=6'b000010.
- Saturation and clear: preload hit_count to 254, then draw_req=4'b1111. Expect hit_count=255. With count_clr and a pulse in the same cycle, expect hit_count=0 next cycle.
- Async reset: drop resetN mid-frame with flags set. Expect all outputs 0 immediately. After release, draw_req=4'b0011 fires a pulse before any startOfFrame.
